err_evt_sched: RTL and testbench
================================

ERR_EVT_SCHED -- requirements
Module: err_evt_sched

Interface
REQ-001 The block SHALL have these ports: clock, input, 1, system clock; all state updates on the rising edge.
REQ-002 The block SHALL have these ports: reset, input, 1, synchronous, active-low; reset reset, synchronous, active-low; clock clock.
REQ-003 The block SHALL have these ports: rx_err, input, 1, MAC receive error (REC +1 request).
REQ-004 The block SHALL have these ports: rx_err_dom, input, 1, MAC dominant bit after error flag (REC +8 request).
REQ-005 The block SHALL have these ports: rx_ok, input, 1, MAC successful reception (REC -1 request).
REQ-006 The block SHALL have these ports: tx_err, input, 1, MAC transmit error (TEC +8 request).
REQ-007 The block SHALL have these ports: tx_ok, input, 1, MAC successful transmission (TEC -1 request).
REQ-008 The block SHALL have these ports: bit_tick, input, 1, one-cycle pulse per sampled bit; bit_rec, input, 1, sampled value, 1 = recessive.
REQ-009 The block SHALL have these ports: bus_off, input, 1, fault FSM in bus-off state.
REQ-010 The block SHALL have these outputs, registered: inconerec, incegtrec, decrec, inctec, dectec, each 1 bit, counter commands.
REQ-011 The block SHALL have these outputs, registered: cnt_reset_n, 1, active-low counter clear; recovery_done, 1, bus-off recovery complete pulse; pending, 1, any event queued.

Function
REQ-012 Each request input SHALL be rising-edge detected and set its own sticky pending bit (5 bits); a level held high SHALL queue exactly one event.
REQ-013 rx_err and rx_err_dom rising in the same cycle SHALL queue only the +8 event.
REQ-014 The scheduler FSM SHALL have states IDLE, ISSUE and GAP.
REQ-015 IDLE->ISSUE SHALL occur when any pending bit is set; the highest-priority event SHALL be selected in this order: tx_err, rx_err_dom, rx_err, tx_ok, rx_ok.
REQ-016 In ISSUE exactly one command output SHALL be high for exactly one cycle, and the selected pending bit SHALL clear; ISSUE SHALL always go to GAP.
REQ-017 In GAP all commands SHALL be low for one cycle, re-arming the downstream edge detector; GAP->ISSUE if pending, else GAP->IDLE.
REQ-018 Latency SHALL be: event edge sampled at edge k, command high during the cycle after edge k+1; maximum throughput is one command per 2 cycles.
REQ-019 An event arriving while the same pending bit is already set SHALL be merged and not counted twice.
REQ-020 While bus_off=1, all pending bits SHALL clear, no commands SHALL issue, new requests SHALL be ignored, and the FSM SHALL return to IDLE at the next edge.
REQ-021 Bus-off recovery: a 4-bit run counter SHALL increment on bit_tick with bit_rec=1 and reset to 0 on bit_tick with bit_rec=0.
REQ-022 At a run count of 11 the run counter SHALL reset to 0 and an 8-bit occurrence counter SHALL increment.
REQ-023 When the occurrence counter reaches 128, recovery_done and cnt_reset_n=0 SHALL assert for exactly one cycle, and both counters SHALL clear.
REQ-024 The recovery counters SHALL be held at 0 whenever bus_off=0; bus_off deasserting mid-recovery SHALL abort recovery without a pulse.
REQ-025 pending SHALL equal the OR of the pending bits, registered.

Reset
REQ-026 On reset=0: FSM=IDLE; pending bits, edge history, run and occurrence counters=0; all command outputs=0; recovery_done=0; cnt_reset_n=1; pending=0.
REQ-027 Reset asserted mid-ISSUE SHALL drop the command in the next cycle without a partial pulse; the event SHALL be lost.

Structure
REQ-028 Package err_sched_pkg SHALL hold the state encoding, the event index and priority constants, RECESSIVE_RUN=11 and RECOVERY_RUNS=128.
REQ-029 Sub-module busoff_recovery_cnt SHALL contain the run and occurrence counters plus the recovery_done/cnt_reset_n generation.

Verification
REQ-030 Single rx_err pulse -> inconerec high for exactly 1 cycle, 2 cycles after the edge; pending returns to 0.
REQ-031 tx_err, rx_err and rx_ok rise in the same cycle -> inctec, GAP, inconerec, GAP, decrec, with single-cycle pulses 2 cycles apart.
REQ-032 rx_err and rx_err_dom rise together -> only incegtrec, once; rx_err held high for 10 cycles -> one inconerec.
REQ-033 bus_off=1 with 3 events pending -> no commands issued, pending=0; then 128x11 recessive ticks -> recovery_done and cnt_reset_n=0 for 1 cycle on the final tick.
REQ-034 A dominant tick after 10 recessive ticks -> run count returns to 0 and the occurrence count is unchanged; bus_off dropped at occurrence 64 -> no recovery_done pulse.
REQ-035 reset=0 asserted during ISSUE -> all outputs at their reset values at the next edge, and no further commands issue.

Source files
------------

// File: rtl/err_sched_pkg.sv
// Shared definitions for the CAN error-event scheduler: FSM encoding, event
// indices (ordered by priority) and bus-off recovery constants.
package err_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_e;

  localparam int NUM_EVT = 5;

  // Index order is priority order: index 0 wins over every other pending event.
  localparam int EVT_TX_ERR     = 0;
  localparam int EVT_RX_ERR_DOM = 1;
  localparam int EVT_RX_ERR     = 2;
  localparam int EVT_TX_OK      = 3;
  localparam int EVT_RX_OK      = 4;

  localparam int RECESSIVE_RUN = 11;
  localparam int RECOVERY_RUNS = 128;

  // Isolates the lowest set bit, i.e. the highest-priority pending event.
  function automatic logic [NUM_EVT-1:0] pick_highest(input logic [NUM_EVT-1:0] p);
    return p & (~p + NUM_EVT'(1));
  endfunction

endpackage

// File: rtl/busoff_recovery_cnt.sv
// Bus-off recovery detector: counts runs of 11 recessive bits and pulses
// recovery_done / cnt_reset_n after 128 of them while bus-off is held.
module busoff_recovery_cnt
  import err_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       bus_off,
  input  logic       bit_tick,
  input  logic       bit_rec,
  output logic       recovery_done_o,
  output logic       cnt_reset_n_o,
  output logic [3:0] run_o,
  output logic [7:0] occ_o
);

  localparam logic [3:0] RUN_LAST = 4'(RECESSIVE_RUN - 1);
  localparam logic [7:0] OCC_LAST = 8'(RECOVERY_RUNS - 1);

  logic [3:0] run_q, run_d;
  logic [7:0] occ_q, occ_d;
  logic       done_q, done_d;
  logic       cnt_reset_n_q;

  always_comb begin
    run_d  = run_q;
    occ_d  = occ_q;
    done_d = 1'b0;
    if (!bus_off) begin
      // Leaving bus-off aborts any partial recovery silently.
      run_d = '0;
      occ_d = '0;
    end else if (bit_tick) begin
      if (!bit_rec) begin
        run_d = '0;
      end else if (run_q == RUN_LAST) begin
        run_d = '0;
        if (occ_q == OCC_LAST) begin
          occ_d  = '0;
          done_d = 1'b1;
        end else begin
          occ_d = occ_q + 8'd1;
        end
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      run_q         <= '0;
      occ_q         <= '0;
      done_q        <= 1'b0;
      cnt_reset_n_q <= 1'b1;
    end else begin
      run_q         <= run_d;
      occ_q         <= occ_d;
      done_q        <= done_d;
      cnt_reset_n_q <= ~done_d;
    end
  end

  assign recovery_done_o = done_q;
  assign cnt_reset_n_o   = cnt_reset_n_q;
  assign run_o           = run_q;
  assign occ_o           = occ_q;

endmodule

// File: rtl/err_evt_sched.sv
// Serialises MAC error/success events into single-cycle REC/TEC counter
// commands separated by an idle gap, and hosts the bus-off recovery detector.
module err_evt_sched
  import err_sched_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_err,
  input  logic       rx_err_dom,
  input  logic       rx_ok,
  input  logic       tx_err,
  input  logic       tx_ok,
  input  logic       bit_tick,
  input  logic       bit_rec,
  input  logic       bus_off,
  output logic       inconerec,
  output logic       incegtrec,
  output logic       decrec,
  output logic       inctec,
  output logic       dectec,
  output logic       cnt_reset_n,
  output logic       recovery_done,
  output logic       pending,
  output logic [1:0] dbg_state_o,
  output logic [3:0] dbg_run_o,
  output logic [7:0] dbg_occ_o
);

  // Handshake: none. Requests are level inputs whose rising edges are captured
  // into sticky pending bits; commands are fire-and-forget single-cycle pulses.

  logic [NUM_EVT-1:0] req;
  logic [NUM_EVT-1:0] prev_q;
  logic [NUM_EVT-1:0] rise;
  logic [NUM_EVT-1:0] pend_q, pend_d;
  logic [NUM_EVT-1:0] sel;
  logic [NUM_EVT-1:0] clr;
  logic [NUM_EVT-1:0] cmd_q, cmd_d;
  logic               pending_q;
  sched_state_e       state_q, state_d;

  always_comb begin
    req                 = '0;
    req[EVT_TX_ERR]     = tx_err;
    req[EVT_RX_ERR_DOM] = rx_err_dom;
    req[EVT_RX_ERR]     = rx_err;
    req[EVT_TX_OK]      = tx_ok;
    req[EVT_RX_OK]      = rx_ok;
  end

  always_comb begin
    rise = req & ~prev_q;
    // A simultaneous +1 and +8 receive error is one error; keep only the +8.
    if (rise[EVT_RX_ERR_DOM]) begin
      rise[EVT_RX_ERR] = 1'b0;
    end
  end

  assign sel = pick_highest(pend_q);

  always_comb begin
    state_d = state_q;
    cmd_d   = '0;
    clr     = '0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (|pend_q) begin
          state_d = ST_ISSUE;
          cmd_d   = sel;
          clr     = sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_GAP;
      default:  state_d = ST_IDLE;
    endcase
    pend_d = (pend_q & ~clr) | rise;
    if (bus_off) begin
      state_d = ST_IDLE;
      cmd_d   = '0;
      pend_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      prev_q    <= '0;
      pend_q    <= '0;
      cmd_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= req;
      pend_q    <= pend_d;
      cmd_q     <= cmd_d;
      pending_q <= |pend_d;
    end
  end

  assign inctec    = cmd_q[EVT_TX_ERR];
  assign incegtrec = cmd_q[EVT_RX_ERR_DOM];
  assign inconerec = cmd_q[EVT_RX_ERR];
  assign dectec    = cmd_q[EVT_TX_OK];
  assign decrec    = cmd_q[EVT_RX_OK];
  assign pending   = pending_q;
  assign dbg_state_o = state_q;

  busoff_recovery_cnt u_recovery (
    .clock           (clock),
    .reset           (reset),
    .bus_off         (bus_off),
    .bit_tick        (bit_tick),
    .bit_rec         (bit_rec),
    .recovery_done_o (recovery_done),
    .cnt_reset_n_o   (cnt_reset_n),
    .run_o           (dbg_run_o),
    .occ_o           (dbg_occ_o)
  );

endmodule

// File: tb/tb_err_evt_sched.sv
// Bench for err_evt_sched: directed scenarios plus randomized event traffic
// checked against a cycle-level behavioural model of the scheduling rules.
module tb_err_evt_sched;

  logic       clock;
  logic       reset;
  logic       rx_err, rx_err_dom, rx_ok, tx_err, tx_ok;
  logic       bit_tick, bit_rec, bus_off;
  logic       inconerec, incegtrec, decrec, inctec, dectec;
  logic       cnt_reset_n, recovery_done, pending;
  logic [1:0] dbg_state;
  logic [3:0] dbg_run;
  logic [7:0] dbg_occ;
  logic [4:0] cmd;

  int n_tests = 0;
  int n_fail  = 0;

  // Bench command vector: bit 0 tx_err/inctec, 1 rx_err_dom/incegtrec,
  // 2 rx_err/inconerec, 3 tx_ok/dectec, 4 rx_ok/decrec (priority order).
  localparam logic [4:0] C_INCTEC = 5'b00001;
  localparam logic [4:0] C_INCEGT = 5'b00010;
  localparam logic [4:0] C_INCONE = 5'b00100;
  localparam logic [4:0] C_DECTEC = 5'b01000;
  localparam logic [4:0] C_DECREC = 5'b10000;

  assign cmd = {decrec, dectec, inconerec, incegtrec, inctec};

  err_evt_sched dut (
    .clock         (clock),
    .reset         (reset),
    .rx_err        (rx_err),
    .rx_err_dom    (rx_err_dom),
    .rx_ok         (rx_ok),
    .tx_err        (tx_err),
    .tx_ok         (tx_ok),
    .bit_tick      (bit_tick),
    .bit_rec       (bit_rec),
    .bus_off       (bus_off),
    .inconerec     (inconerec),
    .incegtrec     (incegtrec),
    .decrec        (decrec),
    .inctec        (inctec),
    .dectec        (dectec),
    .cnt_reset_n   (cnt_reset_n),
    .recovery_done (recovery_done),
    .pending       (pending),
    .dbg_state_o   (dbg_state),
    .dbg_run_o     (dbg_run),
    .dbg_occ_o     (dbg_occ)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [4:0] r);
    tx_err     = r[0];
    rx_err_dom = r[1];
    rx_err     = r[2];
    tx_ok      = r[3];
    rx_ok      = r[4];
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_req(5'b0);
    bit_tick = 1'b0;
    bit_rec  = 1'b0;
    bus_off  = 1'b0;
    idle(3);
    n_tests++;
    if ({cmd, pending, recovery_done, cnt_reset_n} !== 8'b0000_0001) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd=%b pend=%b done=%b crn=%b, want 0 0 0 1",
               cmd, pending, recovery_done, cnt_reset_n);
    end
    n_tests++;
    if ({dbg_state, dbg_run, dbg_occ} !== 14'b0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d run=%0d occ=%0d, want 0 0 0", dbg_state, dbg_run, dbg_occ);
    end
    reset = 1'b1;
    idle(2);
  endtask

  task automatic test_single_rx_err();
    logic [4:0] exp_cmd;
    logic [1:0] exp_st;
    set_req(C_INCONE);
    tick();
    set_req(5'b0);
    n_tests++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pending_set: got %b want 1", pending);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      exp_cmd = (i == 1) ? C_INCONE : 5'b0;
      exp_st  = (i == 1) ? 2'd1 : (i == 2) ? 2'd2 : 2'd0;
      n_tests++;
      if (cmd !== exp_cmd || dbg_state !== exp_st) begin
        n_fail++;
        $display("FAIL single_rx_err[%0d]: got cmd=%b st=%0d want cmd=%b st=%0d", i, cmd, dbg_state, exp_cmd, exp_st);
      end
    end
    n_tests++;
    if (pending !== 1'b0) begin
      n_fail++;
      $display("FAIL single_pending_clear: got %b want 0", pending);
    end
  endtask

  task automatic test_priority();
    logic [4:0] exp_tab [8];
    exp_tab = '{5'b0, C_INCTEC, 5'b0, C_INCONE, 5'b0, C_DECREC, 5'b0, 5'b0};
    set_req(C_INCTEC | C_INCONE | C_DECREC);
    tick();
    set_req(5'b0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      n_tests++;
      if (cmd !== exp_tab[i]) begin
        n_fail++;
        $display("FAIL priority[%0d]: got cmd=%b want %b", i, cmd, exp_tab[i]);
      end
    end
  endtask

  task automatic test_merge();
    int n_egt, n_one, n_other;
    n_egt = 0; n_one = 0; n_other = 0;
    set_req(C_INCONE | C_INCEGT);
    for (int i = 0; i < 10; i++) begin
      tick();
      n_egt   += int'(incegtrec);
      n_one   += int'(inconerec);
      n_other += int'(inctec | dectec | decrec);
    end
    set_req(5'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_egt += int'(incegtrec);
      n_one += int'(inconerec);
    end
    n_tests++;
    if (n_egt != 1 || n_one != 0 || n_other != 0) begin
      n_fail++;
      $display("FAIL merge_dom: got egt=%0d one=%0d other=%0d want 1 0 0", n_egt, n_one, n_other);
    end
    n_one = 0;
    set_req(C_INCONE);
    for (int i = 0; i < 14; i++) begin
      if (i == 10) set_req(5'b0);
      tick();
      n_one += int'(inconerec);
    end
    n_tests++;
    if (n_one != 1) begin
      n_fail++;
      $display("FAIL merge_held: got %0d inconerec pulses want 1", n_one);
    end
  endtask

  // Model: an event is queued on each rising request; commands need at least
  // one empty cycle between them; the highest-priority queued event goes first.
  task automatic test_random();
    logic [4:0] cur, mprev, mpend, rise, exp_cmd;
    logic       issued_last;
    int         nerr;
    cur = '0; mprev = '0; mpend = '0; issued_last = 1'b0; nerr = 0;
    set_req(cur);
    idle(4);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      set_req(cur);
      rise = cur & ~mprev;
      if (rise[1]) rise[2] = 1'b0;
      mprev   = cur;
      exp_cmd = '0;
      if (!issued_last && mpend != 0) begin
        for (int b = 4; b >= 0; b--)
          if (mpend[b]) exp_cmd = 5'(1 << b);
        mpend       = mpend & ~exp_cmd;
        issued_last = 1'b1;
      end else begin
        issued_last = 1'b0;
      end
      mpend = mpend | rise;
      tick();
      n_tests++;
      if (cmd !== exp_cmd || pending !== (mpend != 0)) begin
        n_fail++;
        if (nerr++ < 10)
          $display("FAIL random[%0d]: got cmd=%b pend=%b want cmd=%b pend=%b", cyc, cmd, pending, exp_cmd, mpend != 0);
      end
    end
    set_req(5'b0);
    idle(12);
  endtask

  task automatic test_bus_off();
    int ntick, nerr;
    set_req(C_INCTEC | C_DECTEC | C_DECREC);
    tick();
    bus_off = 1'b1;
    n_tests++;
    if (pending !== 1'b1) begin
      n_fail++;
      $display("FAIL busoff_queued: got pending=%b want 1", pending);
    end
    for (int i = 0; i < 8; i++) begin
      if (i == 2) set_req(C_INCONE | C_INCTEC | C_DECTEC | C_DECREC);
      tick();
      n_tests++;
      if (cmd !== 5'b0 || pending !== 1'b0 || dbg_state !== 2'd0) begin
        n_fail++;
        $display("FAIL busoff_quiet[%0d]: got cmd=%b pend=%b st=%0d want 0 0 0", i, cmd, pending, dbg_state);
      end
    end
    set_req(5'b0);
    // 128 runs of 11 recessive bits, one bit every other cycle.
    ntick = 0; nerr = 0;
    bit_rec = 1'b1;
    for (int r = 0; r < 128; r++) begin
      for (int b = 0; b < 11; b++) begin
        bit_tick = 1'b1;
        tick();
        bit_tick = 1'b0;
        ntick++;
        n_tests++;
        if (recovery_done !== (ntick == 1408) || cnt_reset_n !== (ntick != 1408)) begin
          n_fail++;
          if (nerr++ < 10)
            $display("FAIL recovery_tick[%0d]: got done=%b crn=%b want %b %b", ntick, recovery_done, cnt_reset_n, ntick == 1408, ntick != 1408);
        end
        if (ntick == 704) begin
          n_tests++;
          if (dbg_occ !== 8'd64 || dbg_run !== 4'd0) begin
            n_fail++;
            $display("FAIL recovery_mid: got occ=%0d run=%0d want 64 0", dbg_occ, dbg_run);
          end
        end
        tick();
        n_tests++;
        if (recovery_done !== 1'b0 || cnt_reset_n !== 1'b1) begin
          n_fail++;
          if (nerr++ < 10)
            $display("FAIL recovery_gap[%0d]: got done=%b crn=%b want 0 1", ntick, recovery_done, cnt_reset_n);
        end
      end
    end
    n_tests++;
    if (dbg_occ !== 8'd0 || dbg_run !== 4'd0) begin
      n_fail++;
      $display("FAIL recovery_clear: got occ=%0d run=%0d want 0 0", dbg_occ, dbg_run);
    end
    bus_off = 1'b0;
    idle(3);
    n_tests++;
    if (cmd !== 5'b0 || pending !== 1'b0) begin
      n_fail++;
      $display("FAIL busoff_exit: got cmd=%b pend=%b want 0 0", cmd, pending);
    end
  endtask

  task automatic recessive_bits(input int n);
    bit_rec = 1'b1;
    for (int i = 0; i < n; i++) begin
      bit_tick = 1'b1;
      tick();
      bit_tick = 1'b0;
      if (recovery_done) n_fail++;
    end
  endtask

  task automatic test_dominant_abort();
    int fail_before;
    bus_off = 1'b1;
    tick();
    fail_before = n_fail;
    recessive_bits(33);
    n_tests++;
    if (dbg_occ !== 8'd3 || dbg_run !== 4'd0) begin
      n_fail++;
      $display("FAIL dom_runs: got occ=%0d run=%0d want 3 0", dbg_occ, dbg_run);
    end
    recessive_bits(10);
    n_tests++;
    if (dbg_run !== 4'd10) begin
      n_fail++;
      $display("FAIL dom_run10: got run=%0d want 10", dbg_run);
    end
    bit_rec  = 1'b0;
    bit_tick = 1'b1;
    tick();
    bit_tick = 1'b0;
    n_tests++;
    if (dbg_run !== 4'd0 || dbg_occ !== 8'd3) begin
      n_fail++;
      $display("FAIL dom_reset: got run=%0d occ=%0d want 0 3", dbg_run, dbg_occ);
    end
    recessive_bits(61 * 11);
    n_tests++;
    if (dbg_occ !== 8'd64) begin
      n_fail++;
      $display("FAIL abort_occ64: got occ=%0d want 64", dbg_occ);
    end
    bus_off = 1'b0;
    recessive_bits(5);
    n_tests++;
    if (dbg_occ !== 8'd0 || dbg_run !== 4'd0) begin
      n_fail++;
      $display("FAIL abort_clear: got occ=%0d run=%0d want 0 0", dbg_occ, dbg_run);
    end
    n_tests++;
    if (n_fail != fail_before) begin
      $display("FAIL abort_no_pulse: got %0d unexpected recovery_done pulses want 0", n_fail - fail_before);
    end
  endtask

  task automatic test_reset_in_issue();
    int n_cmd;
    set_req(C_INCTEC | C_DECREC);
    tick();
    set_req(5'b0);
    tick();
    n_tests++;
    if (cmd !== C_INCTEC) begin
      n_fail++;
      $display("FAIL rst_issue_pre: got cmd=%b want %b", cmd, C_INCTEC);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if ({cmd, pending, recovery_done, cnt_reset_n, dbg_state} !== 10'b00000_0_0_1_00) begin
      n_fail++;
      $display("FAIL rst_issue_drop: got cmd=%b pend=%b done=%b crn=%b st=%0d want 0 0 0 1 0",
               cmd, pending, recovery_done, cnt_reset_n, dbg_state);
    end
    reset = 1'b1;
    n_cmd = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmd += int'(|cmd);
    end
    n_tests++;
    if (n_cmd != 0) begin
      n_fail++;
      $display("FAIL rst_issue_lost: got %0d commands after reset want 0", n_cmd);
    end
  endtask

  initial begin
    test_reset();
    test_single_rx_err();
    test_priority();
    test_merge();
    test_random();
    test_bus_off();
    test_dominant_abort();
    test_reset_in_issue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
